wave_pattern_gen: RTL and testbench

Synthesizable, table-driven waveform generator. Drives NCH output signals through a programmed sequence of up to DEPTH segments. Each segment holds one NCH-bit value for a programmed number of clk cycles. Replaces hand-written delay-chained stimulus: benches and on-chip test logic program the table, pulse start, and get cycle-exact waveforms with optional looping.

---
 rtl/wave_pattern_pkg.sv | 16 +
 rtl/wave_pattern_gen_if.sv | 31 +++
 rtl/wave_pattern_table.sv | 24 ++
 rtl/wave_pattern_gen.sv | 134 +++++++++++++
 tb/tb_wave_pattern_gen.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wave_pattern_pkg.sv
// Shared types and helpers for the table-driven waveform generator.
package wave_pattern_pkg;

    // Sequencer state: either waiting for start or playing the table.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Number of segments actually played: a request longer than the table
    // plays the whole table once per pass.
    function automatic int unsigned clamp_len(input int unsigned n, input int unsigned depth);
        return (n > depth) ? depth : n;
    endfunction

endpackage

// File: rtl/wave_pattern_gen_if.sv
// Control/table/status bundle of the waveform generator.
interface wave_pattern_gen_if #(
    parameter int NCH   = 2,
    parameter int DEPTH = 8,
    parameter int DUR_W = 16
);
    localparam int AW = $clog2(DEPTH);

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DUR_W-1:0] wr_dur;
    logic [NCH-1:0]   wr_val;
    logic [AW:0]      num_seg;
    logic             loop_en;
    logic             start;
    logic             stop;
    logic [NCH-1:0]   sig_out;
    logic             busy;
    logic             done;
    logic [AW-1:0]    seg_idx;

    modport master (
        output wr_en, wr_addr, wr_dur, wr_val, num_seg, loop_en, start, stop,
        input  sig_out, busy, done, seg_idx
    );

    modport slave (
        input  wr_en, wr_addr, wr_dur, wr_val, num_seg, loop_en, start, stop,
        output sig_out, busy, done, seg_idx
    );
endinterface

// File: rtl/wave_pattern_table.sv
// Segment table: one synchronous write port, one combinational read port.
// Contents are intentionally not reset; entries are undefined until written.
module wave_pattern_table #(
    parameter int DEPTH = 8,
    parameter int W     = 18
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [W-1:0]             wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [W-1:0]             rd_data
);
    logic [W-1:0] mem [DEPTH];

    // Table write, allowed in any sequencer state.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/wave_pattern_gen.sv
// Table-driven waveform generator: plays up to DEPTH segments, each holding
// one NCH-bit value for a programmed number of cycles, with optional looping.
module wave_pattern_gen
    import wave_pattern_pkg::*;
#(
    parameter int             NCH      = 2,
    parameter int             DEPTH    = 8,
    parameter int             DUR_W    = 16,
    parameter logic [NCH-1:0] IDLE_VAL = '0
) (
    input logic               clk,
    input logic               rst,
    wave_pattern_gen_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [DUR_W-1:0] dur;
        logic [NCH-1:0]   val;
    } seg_t;

    state_t           state_reg, state_next;
    logic [DUR_W-1:0] cnt_reg, cnt_next;
    logic [LW-1:0]    len_reg, len_next;
    logic [AW-1:0]    seg_idx_reg, seg_idx_next;
    logic [NCH-1:0]   sig_reg, sig_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    seg_t             wr_seg;
    seg_t             rd_seg;
    logic [AW-1:0]    rd_addr;
    logic             last_seg;
    logic [DUR_W-1:0] rd_dur_eff;

    assign wr_seg = '{dur: bus.wr_dur, val: bus.wr_val};

    wave_pattern_table #(
        .DEPTH (DEPTH),
        .W     (DUR_W + NCH)
    ) u_table (
        .clk     (clk),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (wr_seg),
        .rd_addr (rd_addr),
        .rd_data (rd_seg)
    );

    // Look-ahead: the table is always addressed by the entry that would be
    // loaded at the next segment boundary, so loads never leave a gap cycle.
    always_comb begin
        last_seg   = ({1'b0, seg_idx_reg} == (len_reg - LW'(1)));
        rd_addr    = (state_reg == RUN && !last_seg) ? seg_idx_reg + AW'(1) : '0;
        rd_dur_eff = (rd_seg.dur == '0) ? DUR_W'(1) : rd_seg.dur;
    end

    // Sequencer next-state, countdown and output decode.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        len_next     = len_reg;
        seg_idx_next = seg_idx_reg;
        sig_next     = sig_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (bus.start && !bus.stop && bus.num_seg != '0) begin
                    state_next   = RUN;
                    len_next     = LW'(clamp_len(int'(bus.num_seg), DEPTH));
                    seg_idx_next = '0;
                    sig_next     = rd_seg.val;
                    cnt_next     = rd_dur_eff;
                    busy_next    = 1'b1;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    // Abort wins over a coincident end of pattern: no done.
                    state_next   = IDLE;
                    sig_next     = IDLE_VAL;
                    busy_next    = 1'b0;
                    seg_idx_next = '0;
                    cnt_next     = '0;
                end else if (cnt_reg == DUR_W'(1)) begin
                    if (last_seg && !bus.loop_en) begin
                        state_next   = IDLE;
                        sig_next     = IDLE_VAL;
                        busy_next    = 1'b0;
                        seg_idx_next = '0;
                        cnt_next     = '0;
                        done_next    = 1'b1;
                    end else begin
                        // Next entry, or entry 0 when wrapping a looped pattern.
                        seg_idx_next = rd_addr;
                        sig_next     = rd_seg.val;
                        cnt_next     = rd_dur_eff;
                    end
                end else begin
                    cnt_next = cnt_reg - DUR_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            len_reg     <= '0;
            seg_idx_reg <= '0;
            sig_reg     <= IDLE_VAL;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            len_reg     <= len_next;
            seg_idx_reg <= seg_idx_next;
            sig_reg     <= sig_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    assign bus.sig_out = sig_reg;
    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.seg_idx = seg_idx_reg;
endmodule

// File: tb/tb_wave_pattern_gen.sv
// Self-checking bench for wave_pattern_gen: a table model expands each
// started pattern into per-cycle expected outputs in a scoreboard queue.
module tb_wave_pattern_gen;
    localparam int NCH   = 2;
    localparam int DEPTH = 8;
    localparam int DUR_W = 16;

    typedef struct packed {
        logic [1:0] sig;
        logic       busy;
        logic       done;
        logic [2:0] idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wave_pattern_gen_if #(.NCH(NCH), .DEPTH(DEPTH), .DUR_W(DUR_W)) bus ();

    wave_pattern_gen #(
        .NCH      (NCH),
        .DEPTH    (DEPTH),
        .DUR_W    (DUR_W),
        .IDLE_VAL (2'b00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned m_dur [DEPTH];
    logic [1:0]  m_val [DEPTH];

    // Advance one cycle without checking; one-shot inputs drop afterwards.
    task automatic step();
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.wr_en = 1'b0;
    endtask

    // Compare the DUT outputs of this cycle against the oldest expectation.
    task automatic check_one(input string name);
        exp_t e;
        exp_t g;
        @(negedge clk);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, nothing required", name);
        end else begin
            e = exp_q.pop_front();
            g = {bus.sig_out, bus.busy, bus.done, bus.seg_idx};
            if (g !== e) begin
                errors++;
                $display("FAIL %s: got sig=%b busy=%b done=%b idx=%0d required sig=%b busy=%b done=%b idx=%0d",
                         name, g.sig, g.busy, g.done, g.idx, e.sig, e.busy, e.done, e.idx);
            end
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.wr_en = 1'b0;
    endtask

    task automatic drain(input string name);
        while (exp_q.size() > 0) check_one(name);
    endtask

    task automatic drain_n(input string name, input int n);
        for (int i = 0; i < n; i++) check_one(name);
    endtask

    task automatic write_entry(input int a, input int unsigned d, input logic [1:0] v);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'(a);
        bus.wr_dur  = 16'(d);
        bus.wr_val  = v;
        m_dur[a]    = d;
        m_val[a]    = v;
        $display("write entry %0d dur=%0d val=%b", a, d, v);
    endtask

    task automatic load_entry(input int a, input int unsigned d, input logic [1:0] v);
        write_entry(a, d, v);
        step();
    endtask

    task automatic push_seg(input int i);
        int unsigned n;
        n = (m_dur[i] == 0) ? 1 : m_dur[i];
        for (int unsigned k = 0; k < n; k++) exp_q.push_back({m_val[i], 1'b1, 1'b0, 3'(i)});
    endtask

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back({2'b00, 1'b0, 1'b0, 3'd0});
    endtask

    task automatic push_done();
        exp_q.push_back({2'b00, 1'b0, 1'b1, 3'd0});
        push_idle(1);
    endtask

    task automatic do_start(input int n, input logic lp);
        bus.num_seg = 4'(n);
        bus.loop_en = lp;
        bus.start   = 1'b1;
        $display("start num_seg=%0d loop_en=%b", n, lp);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        push_idle(2);
        drain("reset_hold");
        rst = 1'b0;
        push_idle(2);
        drain("reset_release");
    endtask

    task automatic test_basic();
        load_entry(0, 5, 2'b00);
        load_entry(1, 15, 2'b01);
        load_entry(2, 20, 2'b00);
        load_entry(3, 15, 2'b01);
        load_entry(4, 10, 2'b00);
        do_start(5, 1'b0);
        for (int i = 0; i < 5; i++) push_seg(i);
        push_done();
        drain("basic");
    endtask

    task automatic test_loop();
        load_entry(0, 3, 2'b01);
        load_entry(1, 2, 2'b10);
        do_start(2, 1'b1);
        for (int p = 0; p < 3; p++) begin
            push_seg(0);
            push_seg(1);
        end
        push_seg(0);
        exp_q.push_back({2'b10, 1'b1, 1'b0, 3'd1});
        drain("loop_run");
        bus.loop_en = 1'b0;
        exp_q.push_back({2'b10, 1'b1, 1'b0, 3'd1});
        push_done();
        drain("loop_exit");
    endtask

    task automatic test_zero_and_clamp();
        load_entry(0, 1, 2'b01);
        load_entry(1, 2, 2'b10);
        load_entry(2, 0, 2'b11);
        load_entry(3, 1, 2'b00);
        load_entry(4, 3, 2'b01);
        load_entry(5, 1, 2'b10);
        load_entry(6, 2, 2'b11);
        load_entry(7, 1, 2'b01);
        do_start(DEPTH + 1, 1'b0);
        for (int i = 0; i < DEPTH; i++) push_seg(i);
        push_done();
        drain("clamp_zero_dur");
        do_start(0, 1'b0);
        push_idle(4);
        drain("num_seg_zero");
        do_start(3, 1'b0);
        bus.stop = 1'b1;
        push_idle(3);
        drain("start_with_stop");
    endtask

    task automatic test_stop();
        do_start(3, 1'b0);
        push_seg(0);
        push_seg(1);
        drain_n("stop_mid_run", 2);
        bus.stop = 1'b1;
        exp_q.delete();
        push_idle(3);
        drain("stop_mid_after");
        do_start(2, 1'b0);
        push_seg(0);
        push_seg(1);
        drain("stop_last_run");
        bus.stop = 1'b1;
        push_idle(3);
        drain("stop_last_after");
    endtask

    task automatic test_back_to_back();
        do_start(5, 1'b0);
        for (int i = 0; i < 5; i++) push_seg(i);
        push_done();
        drain_n("restart_run", 3);
        bus.start   = 1'b1;
        bus.num_seg = 4'd1;
        drain("restart_ignored");
    endtask

    task automatic test_live_write();
        load_entry(0, 3, 2'b01);
        load_entry(1, 2, 2'b10);
        do_start(2, 1'b1);
        push_seg(0);
        push_seg(1);
        check_one("live_first");
        write_entry(0, 4, 2'b11);
        drain("live_old_pass");
        push_seg(0);
        drain_n("live_new_pass", 2);
        rst = 1'b1;
        exp_q.delete();
        push_idle(2);
        drain("mid_reset");
        rst = 1'b0;
        bus.loop_en = 1'b0;
        push_idle(2);
        drain("after_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_dur  = '0;
        bus.wr_val  = '0;
        bus.num_seg = '0;
        bus.loop_en = 1'b0;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        test_reset();
        test_basic();
        test_loop();
        test_zero_and_clamp();
        test_stop();
        test_back_to_back();
        test_live_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
